dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_wait_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDRESS_WIDTH = 20;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_MAX_WAIT      = 8;

    // Width of the beat counter (l_len) and of the starvation counter.
    localparam int CNT_W = 4;

    // Who currently drives the memory port.
    typedef enum logic {
        PIPE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Which requester a returning read word belongs to.
    typedef enum logic {
        OWN_PIPE   = 1'b0,
        OWN_LOADER = 1'b1
    } rd_owner_e;

    // Saturation value of the starvation counter for a given MAX_WAIT.
    function automatic logic [CNT_W-1:0] wait_limit(input int max_wait);
        return CNT_W'(max_wait - 1);
    endfunction

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// Saturating starvation counter: counts cycles the loader has been kept
// waiting and flags when the pipeline must yield.
module dmem_arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = wait_limit(MAX_WAIT);

    assign at_limit = (count == LIMIT);

    // Clear wins over increment; the count holds once it reaches LIMIT.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a burst loader.
// The pipeline owns the port by default; the loader takes it for a whole
// burst when the pipeline is idle or the loader has starved long enough.
//
// Handshake: the loader holds l_req for the full burst and presents one
// beat at a time; a beat is accepted in every cycle l_gnt is high, and the
// loader advances addr/data after such a cycle. l_done accompanies the last
// accepted beat. Dropping l_req before then aborts the burst.
// Read data returns one cycle after the read strobe on whichever of
// p_rvalid/l_rvalid matches the requester that issued it.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     rst,
    // pipeline side
    input  logic                     p_req,
    input  logic                     p_we,
    input  logic                     p_be,
    input  logic [ADDRESS_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0]    p_wdata,
    output logic                     p_stall,
    output logic                     p_rvalid,
    output logic [DATA_WIDTH-1:0]    p_rdata,
    // loader side
    input  logic                     l_req,
    input  logic                     l_we,
    input  logic                     l_be,
    input  logic [ADDRESS_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0]    l_wdata,
    input  logic [CNT_W-1:0]         l_len,
    output logic                     l_gnt,
    output logic                     l_done,
    output logic                     l_rvalid,
    output logic [DATA_WIDTH-1:0]    l_rdata,
    // data memory
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    // debug visibility
    output logic                     dbg_state,
    output logic [CNT_W-1:0]         dbg_beat_cnt,
    output logic [CNT_W-1:0]         dbg_wait_cnt
);

    arb_state_e       state, state_next;
    logic [CNT_W-1:0] beat_cnt, beat_next;
    logic             wait_clr, wait_inc, wait_at_limit;
    logic [CNT_W-1:0] wait_cnt;
    logic             rd_pending;
    rd_owner_e        rd_owner;

    dmem_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .count    (wait_cnt),
        .at_limit (wait_at_limit)
    );

    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;
    assign dbg_wait_cnt = wait_cnt;

    // Port mux, strobes and next-state; strobes are quiet while in reset.
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        p_stall    = 1'b0;
        l_gnt      = 1'b0;
        l_done     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = p_addr;
        mem_wdata  = p_wdata;
        mem_be     = p_be;
        wait_clr   = 1'b1;
        wait_inc   = 1'b0;

        if (state == BURST) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            mem_be    = l_be;
        end

        if (!rst) begin
            unique case (state)
                PIPE: begin
                    mem_we   = p_req & p_we;
                    mem_re   = p_req & ~p_we;
                    wait_inc = l_req;
                    wait_clr = ~l_req;
                    if (l_req && (!p_req || wait_at_limit)) begin
                        state_next = BURST;
                        beat_next  = l_len;
                        wait_clr   = 1'b1;
                    end
                end
                BURST: begin
                    l_gnt   = l_req;
                    mem_we  = l_req & l_we;
                    mem_re  = l_req & ~l_we;
                    p_stall = p_req;
                    if (!l_req) begin
                        // loader withdrew: abort without l_done
                        state_next = PIPE;
                        beat_next  = '0;
                    end else if (beat_cnt == '0) begin
                        l_done     = 1'b1;
                        state_next = PIPE;
                    end else begin
                        beat_next = beat_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = PIPE;
                    beat_next  = '0;
                end
            endcase
        end
    end

    // FSM state and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PIPE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
        end
    end

    // Remember who issued this cycle's read so the return can be routed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_PIPE;
        end else begin
            rd_pending <= mem_re;
            rd_owner   <= (state == BURST) ? OWN_LOADER : OWN_PIPE;
        end
    end

    // Route the returning memory word to its requester; zero otherwise.
    always_comb begin
        p_rvalid = !rst && rd_pending && (rd_owner == OWN_PIPE);
        l_rvalid = !rst && rd_pending && (rd_owner == OWN_LOADER);
        p_rdata  = p_rvalid ? mem_rdata : '0;
        l_rdata  = l_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural reference model.
module tb_dmem_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int MW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p_req, p_we, p_be;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_stall, p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          l_req, l_we, l_be;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [3:0]    l_len;
    logic          l_gnt, l_done, l_rvalid;
    logic [DW-1:0] l_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re, mem_be;
    logic [DW-1:0] mem_rdata;
    logic          dbg_state;
    logic [3:0]    dbg_beat_cnt, dbg_wait_cnt;

    dmem_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_WAIT      (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p_req        (p_req),
        .p_we         (p_we),
        .p_be         (p_be),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_stall      (p_stall),
        .p_rvalid     (p_rvalid),
        .p_rdata      (p_rdata),
        .l_req        (l_req),
        .l_we         (l_we),
        .l_be         (l_be),
        .l_addr       (l_addr),
        .l_wdata      (l_wdata),
        .l_len        (l_len),
        .l_gnt        (l_gnt),
        .l_done       (l_done),
        .l_rvalid     (l_rvalid),
        .l_rdata      (l_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_be       (mem_be),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state),
        .dbg_beat_cnt (dbg_beat_cnt),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[11:0], a} ^ 32'h5A5A_C3C3;
    endfunction

    // Data memory: returns the addressed word one cycle after mem_re.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? mem_word(mem_addr) : '0;
    end

    // ---------------- checking ----------------
    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit  m_burst;   // loader owns the memory port
    int  m_wait;    // cycles the loader has waited while the pipeline kept the port
    int  m_left;    // beats still to transfer in the current burst
    logic [DW:0] exp_q[$];  // {owner_is_loader, data} of the read returning next cycle

    logic          e_we, e_re, e_be, e_gnt, e_done, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    logic          obs_gnt, obs_done, obs_state, obs_stall, obs_prv, obs_lrv;
    logic [DW-1:0] obs_prdata, obs_lrdata;
    logic [3:0]    obs_beat, obs_wait;

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic step();
        logic [DW:0] item;
        if (m_burst) begin
            e_addr = l_addr; e_wdata = l_wdata; e_be = l_be;
            e_gnt = l_req; e_we = l_req & l_we; e_re = l_req & ~l_we;
            e_stall = p_req; e_done = l_req && (m_left == 1);
        end else begin
            e_addr = p_addr; e_wdata = p_wdata; e_be = p_be;
            e_gnt = 1'b0; e_we = p_req & p_we; e_re = p_req & ~p_we;
            e_stall = 1'b0; e_done = 1'b0;
        end
        @(negedge clk);
        if (!rst) begin
            chk("state", 64'(dbg_state), 64'(m_burst));
            chk("beat_cnt", 64'(dbg_beat_cnt), m_burst ? 64'(m_left - 1) : 64'd0);
            chk("wait_cnt", 64'(dbg_wait_cnt), 64'(m_wait));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("mem_re", 64'(mem_re), 64'(e_re));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            chk("mem_be", 64'(mem_be), 64'(e_be));
            chk("l_gnt", 64'(l_gnt), 64'(e_gnt));
            chk("l_done", 64'(l_done), 64'(e_done));
            chk("p_stall", 64'(p_stall), 64'(e_stall));
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                chk("p_rvalid", 64'(p_rvalid), 64'(!item[DW]));
                chk("l_rvalid", 64'(l_rvalid), 64'(item[DW]));
                if (item[DW]) chk("l_rdata", 64'(l_rdata), 64'(item[DW-1:0]));
                else          chk("p_rdata", 64'(p_rdata), 64'(item[DW-1:0]));
            end else begin
                chk("p_rvalid_idle", 64'(p_rvalid), 64'd0);
                chk("l_rvalid_idle", 64'(l_rvalid), 64'd0);
            end
        end
        obs_gnt = l_gnt; obs_done = l_done; obs_state = dbg_state; obs_stall = p_stall;
        obs_prv = p_rvalid; obs_lrv = l_rvalid; obs_prdata = p_rdata; obs_lrdata = l_rdata;
        obs_beat = dbg_beat_cnt; obs_wait = dbg_wait_cnt;
        @(posedge clk);
        if (rst) begin
            m_burst = 0; m_wait = 0; m_left = 0;
            exp_q.delete();
        end else begin
            exp_q.delete();
            if (e_re) exp_q.push_back({m_burst, mem_word(e_addr)});
            if (!m_burst) begin
                if (l_req && (!p_req || m_wait == MW - 1)) begin
                    m_burst = 1; m_left = int'(l_len) + 1; m_wait = 0;
                end else if (l_req) begin
                    if (m_wait < MW - 1) m_wait++;
                end else begin
                    m_wait = 0;
                end
            end else if (!l_req || m_left == 1) begin
                m_burst = 0; m_left = 0;
            end else begin
                m_left--;
            end
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        p_req = 0; p_we = 0; p_be = 0; p_addr = '0; p_wdata = '0;
        l_req = 0; l_we = 0; l_be = 0; l_addr = '0; l_wdata = '0; l_len = '0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gn, first, done_c, st5, stall_bad, abort_c;
        bit dseen, lr_active, last_done;

        rst = 1; drive_idle();
        m_burst = 0; m_wait = 0; m_left = 0;
        for (int i = 0; i < 3; i++) step();
        rst = 0;
        idle(1);
        chk("rst_state", 64'(obs_state), 64'd0);
        chk("rst_stall", 64'(obs_stall), 64'd0);

        // Idle pipeline, 4-beat write burst.
        gn = 0; first = -1; done_c = -1; st5 = -1;
        for (int c = 0; c < 7; c++) begin
            p_req = 0; l_req = (c <= 4); l_we = 1; l_len = 4'd3;
            l_addr = AW'(c); l_wdata = $urandom;
            step();
            if (obs_gnt) begin gn++; if (first < 0) first = c; end
            if (obs_done) done_c = c;
            if (c == 5) st5 = int'(obs_state);
        end
        chk("a_first_gnt", 64'(first), 64'd1);
        chk("a_gnt_cnt", 64'(gn), 64'd4);
        chk("a_done_cyc", 64'(done_c), 64'd4);
        chk("a_state_c5", 64'(st5), 64'd0);
        idle(2);

        // Contention: pipeline reads every cycle, loader must wait MAX_WAIT cycles.
        first = -1; stall_bad = 0; dseen = 0;
        for (int c = 0; c < 16; c++) begin
            p_req = 1; p_we = 0; p_addr = AW'($urandom);
            l_req = !dseen; l_we = 1; l_len = 4'd2; l_addr = AW'($urandom);
            step();
            if (obs_state && first < 0) first = c;
            if (obs_state && !obs_stall) stall_bad++;
            if (obs_done) dseen = 1;
        end
        chk("b_burst_cyc", 64'(first), 64'(MW));
        chk("b_stall_bad", 64'(stall_bad), 64'd0);
        chk("b_done_seen", 64'(dseen), 64'd1);
        idle(2);

        // Read routing: pipeline read at 0x10, then loader read at 0x20.
        drive_idle(); p_req = 1; p_we = 0; p_addr = 20'h00010; step();
        drive_idle(); step();
        chk("c_p_rvalid", 64'(obs_prv), 64'd1);
        chk("c_p_rdata", 64'(obs_prdata), 64'(mem_word(20'h00010)));
        l_req = 1; l_we = 0; l_addr = 20'h00020; l_len = 4'd0; step();
        step();
        chk("c_l_gnt", 64'(obs_gnt), 64'd1);
        chk("c_l_done", 64'(obs_done), 64'd1);
        drive_idle(); step();
        chk("c_l_rvalid", 64'(obs_lrv), 64'd1);
        chk("c_l_rdata", 64'(obs_lrdata), 64'(mem_word(20'h00020)));
        chk("c_p_rvalid_off", 64'(obs_prv), 64'd0);
        idle(2);

        // Abort: 8-beat burst, loader withdraws after 3 beats.
        gn = 0; dseen = 0; abort_c = -1;
        for (int c = 0; c < 24; c++) begin
            p_req = 1; p_we = 1; p_addr = AW'($urandom);
            l_req = (gn < 3); l_we = 1; l_len = 4'd7; l_addr = AW'($urandom);
            if (!l_req && abort_c < 0) abort_c = c;
            step();
            gn += int'(obs_gnt);
            if (obs_done) dseen = 1;
            if (abort_c >= 0 && c == abort_c + 1) begin
                chk("d_state_after", 64'(obs_state), 64'd0);
                chk("d_stall_after", 64'(obs_stall), 64'd0);
            end
        end
        chk("d_gnts", 64'(gn), 64'd3);
        chk("d_no_done", 64'(dseen), 64'd0);
        idle(2);

        // Reset in the middle of a read burst, at beat 2.
        gn = 0;
        drive_idle();
        for (int c = 0; c < 12 && gn < 2; c++) begin
            l_req = 1; l_we = 0; l_len = 4'd7; l_addr = AW'($urandom);
            step();
            gn += int'(obs_gnt);
        end
        rst = 1; step();
        rst = 0; step();
        chk("e_state", 64'(obs_state), 64'd0);
        chk("e_gnt", 64'(obs_gnt), 64'd0);
        chk("e_beat", 64'(obs_beat), 64'd0);
        chk("e_wait", 64'(obs_wait), 64'd0);
        chk("e_p_rvalid", 64'(obs_prv), 64'd0);
        chk("e_l_rvalid", 64'(obs_lrv), 64'd0);
        idle(3);

        // Maximum burst: 16 beats.
        gn = 0; dseen = 0;
        for (int c = 0; c < 24 && !dseen; c++) begin
            l_req = 1; l_we = 1; l_len = 4'd15; l_addr = AW'(c); l_wdata = $urandom;
            step();
            gn += int'(obs_gnt);
            if (obs_done) dseen = 1;
        end
        chk("f_gnts", 64'(gn), 64'd16);
        chk("f_done", 64'(dseen), 64'd1);
        idle(2);

        // Randomized mixed traffic.
        lr_active = 0; last_done = 0;
        for (int c = 0; c < 2500; c++) begin
            p_req = 1'($urandom_range(0, 1)); p_we = 1'($urandom_range(0, 1));
            p_be = 1'($urandom_range(0, 1)); p_addr = AW'($urandom); p_wdata = $urandom;
            if (!lr_active) begin
                if ($urandom_range(0, 5) == 0) lr_active = 1;
            end else if (last_done || $urandom_range(0, 39) == 0) begin
                lr_active = 0;
            end
            l_req = lr_active; l_we = 1'($urandom_range(0, 1)); l_be = 1'($urandom_range(0, 1));
            l_addr = AW'($urandom); l_wdata = $urandom; l_len = 4'($urandom_range(0, 15));
            step();
            last_done = e_done;
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
